// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: request-to-send, 11-bit frame on device clock, ACK check.
// Lines are open-drain: the outputs are pull-low enables only; the top level turns them into 0/Z pins.
module ps2_host_tx #(
  parameter int unsigned CLK_HOLD_CYCLES = 2500,
  parameter int unsigned FIRST_TIMEOUT   = 375000,
  parameter int unsigned BIT_TIMEOUT     = 25000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  input  logic       ps2clk,
  input  logic       ps2data,
  output logic       ps2clk_drive_low,
  output logic       ps2data_drive_low,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_error,
  output logic [3:0] dbg_state
);

  // Request handshake: tx_start is a one-cycle strobe taken only while tx_busy is low
  // (IDLE); a strobe seen while busy is dropped, never queued.
  typedef enum logic [3:0] {
    S_IDLE, S_INHIBIT, S_START, S_RELEASE, S_SEND, S_ACK, S_WAIT_IDLE, S_DONE, S_ERROR
  } state_t;

  localparam logic [18:0] HOLD_LAST = 19'(CLK_HOLD_CYCLES - 1);
  localparam logic [18:0] FIRST_TO  = 19'(FIRST_TIMEOUT);
  localparam logic [18:0] BIT_TO    = 19'(BIT_TIMEOUT);

  state_t      state;
  logic [1:0]  clk_sync, data_sync;
  logic        clk_prev;
  logic        fall, lines_idle, timed_out, ack_missing;
  logic [9:0]  frame;
  logic [3:0]  bit_cnt;
  logic [18:0] hold_cnt, to_cnt;

  assign fall        = clk_prev & ~clk_sync[1];
  assign lines_idle  = clk_sync[1] & data_sync[1];
  assign ack_missing = (state == S_ACK) && fall && data_sync[1];
  assign dbg_state   = state;

  always_comb begin
    timed_out = 1'b0;
    case (state)
      S_RELEASE:    timed_out = !fall && (to_cnt == FIRST_TO);
      S_SEND,
      S_ACK:        timed_out = !fall && (to_cnt == BIT_TO);
      S_WAIT_IDLE:  timed_out = !lines_idle && (to_cnt == BIT_TO);
      default:      timed_out = 1'b0;
    endcase
  end

  // Idle PS/2 lines sit high, so the synchronizers come out of reset high to avoid a false fall.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
      clk_prev  <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[0], ps2clk};
      data_sync <= {data_sync[0], ps2data};
      clk_prev  <= clk_sync[1];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state             <= S_IDLE;
      frame             <= '0;
      bit_cnt           <= '0;
      hold_cnt          <= '0;
      to_cnt            <= '0;
      ps2clk_drive_low  <= 1'b0;
      ps2data_drive_low <= 1'b0;
      tx_busy           <= 1'b0;
      tx_done           <= 1'b0;
      tx_error          <= 1'b0;
    end else if (timed_out || ack_missing) begin
      state             <= S_ERROR;
      tx_error          <= 1'b1;
      tx_busy           <= 1'b0;
      ps2clk_drive_low  <= 1'b0;
      ps2data_drive_low <= 1'b0;
    end else begin
      if (state inside {S_RELEASE, S_SEND, S_ACK, S_WAIT_IDLE})
        to_cnt <= fall ? '0 : to_cnt + 19'd1;
      case (state)
        S_IDLE: begin
          if (tx_start) begin
            frame            <= {1'b1, ~^tx_data, tx_data};
            bit_cnt          <= '0;
            hold_cnt         <= '0;
            tx_busy          <= 1'b1;
            ps2clk_drive_low <= 1'b1;
            state            <= S_INHIBIT;
          end
        end
        S_INHIBIT: begin
          if (hold_cnt == HOLD_LAST) begin
            ps2data_drive_low <= 1'b1;
            state             <= S_START;
          end else begin
            hold_cnt <= hold_cnt + 19'd1;
          end
        end
        S_START: begin
          ps2clk_drive_low <= 1'b0;
          to_cnt           <= '0;
          state            <= S_RELEASE;
        end
        S_RELEASE: begin
          if (fall) begin
            ps2data_drive_low <= ~frame[0];
            bit_cnt           <= 4'd1;
            state             <= S_SEND;
          end
        end
        // bit_cnt indexes the bit presented on this fall; index 9 is the stop bit.
        S_SEND: begin
          if (fall) begin
            ps2data_drive_low <= ~frame[bit_cnt];
            bit_cnt           <= bit_cnt + 4'd1;
            if (bit_cnt == 4'd9)
              state <= S_ACK;
          end
        end
        S_ACK: begin
          if (fall) begin
            bit_cnt <= 4'd11;
            state   <= S_WAIT_IDLE;
          end
        end
        S_WAIT_IDLE: begin
          if (lines_idle) begin
            tx_done <= 1'b1;
            tx_busy <= 1'b0;
            state   <= S_DONE;
          end
        end
        S_DONE: begin
          tx_done <= 1'b0;
          state   <= S_IDLE;
        end
        S_ERROR: begin
          tx_error <= 1'b0;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a 40-cycle-period PS/2 device model on open-drain lines,
// table-driven byte vectors plus hand-written timeout, mid-frame start and reset sequences.
module tb_ps2_host_tx;

  localparam int HOLD = 20;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_start = 1'b0;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;
  logic       ps2clk, ps2data;
  logic       ps2clk_drive_low, ps2data_drive_low, tx_busy, tx_done, tx_error;
  logic [3:0] dbg_state;

  int   n_tests = 0;
  int   n_fail = 0;
  int   n_done = 0;
  int   n_err = 0;
  logic busy_at_done = 1'b1;
  logic [9:0] exp_q[$];

  typedef struct {
    logic [7:0] data;
    bit         ack;
    logic [9:0] exp_bits;
    int         exp_done;
    int         exp_err;
  } vec_t;

  assign ps2clk  = ~(ps2clk_drive_low | dev_clk_low);
  assign ps2data = ~(ps2data_drive_low | dev_data_low);

  always #5 clk = ~clk;

  ps2_host_tx #(
    .CLK_HOLD_CYCLES(20),
    .FIRST_TIMEOUT(400),
    .BIT_TIMEOUT(200)
  ) dut (
    .clk(clk),
    .reset(reset),
    .tx_data(tx_data),
    .tx_start(tx_start),
    .ps2clk(ps2clk),
    .ps2data(ps2data),
    .ps2clk_drive_low(ps2clk_drive_low),
    .ps2data_drive_low(ps2data_drive_low),
    .tx_busy(tx_busy),
    .tx_done(tx_done),
    .tx_error(tx_error),
    .dbg_state(dbg_state)
  );

  always @(negedge clk) begin
    if (tx_done) begin
      n_done       <= n_done + 1;
      busy_at_done <= tx_busy;
    end
    if (tx_error) n_err <= n_err + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] d);
    @(negedge clk);
    tx_data  = d;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    tx_data  = ~d;
  endtask

  // Start condition seen by the device: host clock drive released, data held low.
  task automatic wait_release(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (!ps2clk_drive_low && ps2data_drive_low) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  // Device: 20 low / 20 high per clock, reads data on each rise, ACKs (data low) at fall 11.
  task automatic device_frame(input int n_falls, input bit ack, output logic [9:0] got);
    bit ok;
    got = '0;
    wait_release(ok);
    check("start_condition", 32'(ok), 32'd1);
    if (ok) begin
      repeat (10) @(negedge clk);
      for (int k = 1; k <= n_falls; k++) begin
        if (k == 11 && ack) begin
          dev_data_low = 1'b1;
          repeat (5) @(negedge clk);
        end
        dev_clk_low = 1'b1;
        repeat (20) @(negedge clk);
        dev_clk_low  = 1'b0;
        dev_data_low = 1'b0;
        if (k <= 10) got[k-1] = ps2data;
        repeat (20) @(negedge clk);
      end
    end
  endtask

  task automatic settle();
    int i;
    i = 0;
    while (tx_busy && i < 200) begin
      @(negedge clk);
      i++;
    end
    repeat (5) @(negedge clk);
    check("busy_after", 32'(tx_busy), 32'd0);
    check("drives_after", 32'({ps2clk_drive_low, ps2data_drive_low}), 32'd0);
  endtask

  initial begin
    vec_t       vecs[5];
    logic [9:0] got;
    int         d0, e0, cnt;
    bit         ok;

    // {stop, odd parity, data} as the device reads it, LSB first.
    vecs[0] = '{8'hF4, 1'b1, 10'h2F4, 1, 0};
    vecs[1] = '{8'h00, 1'b1, 10'h300, 1, 0};
    vecs[2] = '{8'hFF, 1'b1, 10'h3FF, 1, 0};
    vecs[3] = '{8'h01, 1'b1, 10'h201, 1, 0};
    vecs[4] = '{8'hED, 1'b0, 10'h3ED, 0, 1};

    repeat (3) @(negedge clk);
    check("reset_outputs", 32'({ps2clk_drive_low, ps2data_drive_low, tx_busy, tx_done, tx_error}), 32'd0);
    check("reset_state", 32'(dbg_state), 32'd0);
    reset = 1'b1;
    repeat (3) @(negedge clk);

    // 0xED with cycle-exact request-to-send timing.
    d0 = n_done; e0 = n_err;
    send_byte(8'hED);
    check("busy_T1", 32'(tx_busy), 32'd1);
    check("clk_drive_T1", 32'({ps2clk_drive_low, ps2data_drive_low}), 32'b10);
    repeat (HOLD - 1) @(negedge clk);
    check("data_drive_before_start", 32'(ps2data_drive_low), 32'd0);
    @(negedge clk);
    check("start_bit", 32'({ps2clk_drive_low, ps2data_drive_low}), 32'b11);
    @(negedge clk);
    check("clk_release", 32'({ps2clk_drive_low, ps2data_drive_low}), 32'b01);
    device_frame(11, 1'b1, got);
    settle();
    check("bits_ED", 32'(got), 32'h3ED);
    check("done_ED", 32'(n_done - d0), 32'd1);
    check("err_ED", 32'(n_err - e0), 32'd0);
    check("busy_low_with_done", 32'(busy_at_done), 32'd0);

    for (int i = 0; i < 5; i++) begin
      d0 = n_done; e0 = n_err;
      exp_q.push_back(vecs[i].exp_bits);
      send_byte(vecs[i].data);
      device_frame(11, vecs[i].ack, got);
      settle();
      check($sformatf("bits_vec%0d", i), 32'(got), 32'(exp_q.pop_front()));
      check($sformatf("done_vec%0d", i), 32'(n_done - d0), 32'(vecs[i].exp_done));
      check($sformatf("err_vec%0d", i), 32'(n_err - e0), 32'(vecs[i].exp_err));
    end

    // Device never clocks: error 401 cycles after the clock release.
    d0 = n_done; e0 = n_err;
    send_byte(8'hF4);
    wait_release(ok);
    check("first_release_seen", 32'(ok), 32'd1);
    cnt = 0;
    while (!tx_error && cnt < 1000) begin
      @(negedge clk);
      cnt++;
    end
    check("first_timeout_cycles", 32'(cnt), 32'd401);
    check("first_timeout_drives", 32'({ps2clk_drive_low, ps2data_drive_low, tx_busy}), 32'd0);
    settle();
    check("first_timeout_done", 32'(n_done - d0), 32'd0);

    // Device stops after fall 5 of 0xED: d3=1 (data released) -> d4=0 (data pulled) marks fall 5.
    d0 = n_done;
    send_byte(8'hED);
    device_frame(4, 1'b1, got);
    check("d3_presented", 32'(ps2data_drive_low), 32'd0);
    dev_clk_low = 1'b1;
    cnt = 0;
    while (!ps2data_drive_low && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    check("fall_to_data_cycles", 32'(cnt), 32'd3);
    cnt = 0;
    while (!tx_error && cnt < 1000) begin
      @(negedge clk);
      cnt++;
      if (cnt == 20) dev_clk_low = 1'b0;
    end
    dev_clk_low = 1'b0;
    check("bit_timeout_cycles", 32'(cnt), 32'd201);
    settle();
    check("bit_timeout_done", 32'(n_done - d0), 32'd0);

    // tx_start mid-frame with a different byte is ignored.
    d0 = n_done;
    send_byte(8'hF4);
    fork
      device_frame(11, 1'b1, got);
      begin
        repeat (150) @(negedge clk);
        tx_data  = 8'h00;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
      end
    join
    settle();
    check("midstart_bits", 32'(got), 32'h2F4);
    check("midstart_done", 32'(n_done - d0), 32'd1);
    repeat (50) @(negedge clk);
    check("midstart_no_second_frame", 32'({ps2clk_drive_low, tx_busy}), 32'd0);

    // Reset at fall 6 of 0x00 (d5=0, so data is being pulled low), then a normal frame.
    send_byte(8'h00);
    device_frame(5, 1'b1, got);
    dev_clk_low = 1'b1;
    repeat (4) @(negedge clk);
    check("pre_reset_active", 32'({ps2data_drive_low, tx_busy}), 32'b11);
    #2 reset = 1'b0;
    #1 check("async_reset_outputs",
             32'({ps2clk_drive_low, ps2data_drive_low, tx_busy, tx_done, tx_error}), 32'd0);
    check("async_reset_state", 32'(dbg_state), 32'd0);
    @(negedge clk);
    dev_clk_low = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    d0 = n_done; e0 = n_err;
    send_byte(8'hFF);
    device_frame(11, 1'b1, got);
    settle();
    check("post_reset_bits", 32'(got), 32'h3FF);
    check("post_reset_done", 32'(n_done - d0), 32'd1);
    check("post_reset_err", 32'(n_err - e0), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
